// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-bundle bit positions, the bubble
// control word, instruction field slices and the ID/EX update modes.
package mips_pipe_pkg;

    localparam int CTRL_REGWR    = 0;
    localparam int CTRL_MEMRD    = 1;
    localparam int CTRL_MEMWR    = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 5;

    localparam logic [7:0] NOP_CTRL = 8'h00;

    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        UPD_ADVANCE = 2'd0,
        UPD_STALL   = 2'd1,
        UPD_FLUSH   = 2'd2
    } upd_mode_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode (IF/ID, regfile, WB port) and the ID/EX stage.
// master = surrounding pipeline, slave = the id_ex_stage block.
interface id_ex_stage_if #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [31:0]       id_pc4;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic              wb_regwr;
    logic [4:0]        wb_wraddr;
    logic [31:0]       wb_data;
    logic              ex_flush;
    logic              id_stall;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       ex_pc4;
    logic [31:0]       ex_rs_val;
    logic [31:0]       ex_rt_val;
    logic [31:0]       ex_imm;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_dst;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_valid, id_instr, id_pc4, id_ctrl, id_uses_rs, id_uses_rt,
        output rd1, rd2, wb_regwr, wb_wraddr, wb_data, ex_flush,
        input  rs_addr, rt_addr, id_stall,
        input  ex_valid, ex_ctrl, ex_pc4, ex_rs_val, ex_rt_val, ex_imm,
        input  ex_rs, ex_rt, ex_dst, stall_cycles
    );

    modport slave (
        input  id_valid, id_instr, id_pc4, id_ctrl, id_uses_rs, id_uses_rt,
        input  rd1, rd2, wb_regwr, wb_wraddr, wb_data, ex_flush,
        output rs_addr, rt_addr, id_stall,
        output ex_valid, ex_ctrl, ex_pc4, ex_rs_val, ex_rt_val, ex_imm,
        output ex_rs, ex_rt, ex_dst, stall_cycles
    );
endinterface

// File: rtl/id_hazard_unit.sv
// Load-use hazard detector: a load in EX whose destination feeds the ID
// instruction forces a one-cycle stall unless EX is flushing anyway.
module id_hazard_unit (
    input  logic       id_valid_i,
    input  logic       ex_valid_i,
    input  logic       ex_memrd_i,
    input  logic       ex_flush_i,
    input  logic       uses_rs_i,
    input  logic       uses_rt_i,
    input  logic [4:0] ex_dst_i,
    input  logic [4:0] rs_addr_i,
    input  logic [4:0] rt_addr_i,
    output logic       id_stall_o
);
    logic rs_match;
    logic rt_match;
    logic hazard;

    assign rs_match = uses_rs_i && (ex_dst_i == rs_addr_i);
    assign rt_match = uses_rt_i && (ex_dst_i == rt_addr_i);

    // $0 never carries a real value, so a load targeting it cannot cause a hazard
    assign hazard = id_valid_i && ex_valid_i && ex_memrd_i && (ex_dst_i != 5'd0)
                    && (rs_match || rt_match);

    assign id_stall_o = hazard && !ex_flush_i;
endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute boundary: regfile read addressing with WB bypass,
// load-use stall, ID/EX pipeline register and a saturating stall counter.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        dst_sel;
    logic [31:0]       op1;
    logic [31:0]       op2;
    logic              id_stall;
    upd_mode_e         upd_mode;
    logic              unused_opcode;

    logic              ex_valid_q,  ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;
    logic [31:0]       ex_pc4_q,    ex_pc4_d;
    logic [31:0]       ex_rs_val_q, ex_rs_val_d;
    logic [31:0]       ex_rt_val_q, ex_rt_val_d;
    logic [31:0]       ex_imm_q,    ex_imm_d;
    logic [4:0]        ex_rs_q,     ex_rs_d;
    logic [4:0]        ex_rt_q,     ex_rt_d;
    logic [4:0]        ex_dst_q,    ex_dst_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    assign rs_addr = bus.id_instr[RS_MSB:RS_LSB];
    assign rt_addr = bus.id_instr[RT_MSB:RT_LSB];
    assign dst_sel = bus.id_ctrl[CTRL_REGDST] ? bus.id_instr[RD_MSB:RD_LSB]
                                              : bus.id_instr[RT_MSB:RT_LSB];
    assign unused_opcode = ^bus.id_instr[31:26];

    // The regfile only updates at the edge, so a same-cycle WB write must be forwarded
    assign op1 = (bus.wb_regwr && (bus.wb_wraddr != 5'd0) && (bus.wb_wraddr == rs_addr))
                 ? bus.wb_data : bus.rd1;
    assign op2 = (bus.wb_regwr && (bus.wb_wraddr != 5'd0) && (bus.wb_wraddr == rt_addr))
                 ? bus.wb_data : bus.rd2;

    id_hazard_unit u_hazard (
        .id_valid_i (bus.id_valid),
        .ex_valid_i (ex_valid_q),
        .ex_memrd_i (ex_ctrl_q[CTRL_MEMRD]),
        .ex_flush_i (bus.ex_flush),
        .uses_rs_i  (bus.id_uses_rs),
        .uses_rt_i  (bus.id_uses_rt),
        .ex_dst_i   (ex_dst_q),
        .rs_addr_i  (rs_addr),
        .rt_addr_i  (rt_addr),
        .id_stall_o (id_stall)
    );

    always_comb begin
        upd_mode = UPD_ADVANCE;
        if (bus.ex_flush) begin
            upd_mode = UPD_FLUSH;
        end else if (id_stall) begin
            upd_mode = UPD_STALL;
        end
    end

    // Flush and stall both insert an all-zero bubble
    always_comb begin
        ex_valid_d  = 1'b0;
        ex_ctrl_d   = CTRL_W'(NOP_CTRL);
        ex_pc4_d    = '0;
        ex_rs_val_d = '0;
        ex_rt_val_d = '0;
        ex_imm_d    = '0;
        ex_rs_d     = '0;
        ex_rt_d     = '0;
        ex_dst_d    = '0;
        if (upd_mode == UPD_ADVANCE) begin
            ex_valid_d  = bus.id_valid;
            ex_ctrl_d   = bus.id_valid ? bus.id_ctrl : CTRL_W'(NOP_CTRL);
            ex_pc4_d    = bus.id_pc4;
            ex_rs_val_d = op1;
            ex_rt_val_d = op2;
            ex_imm_d    = sign_ext16(bus.id_instr[IMM_MSB:IMM_LSB]);
            ex_rs_d     = rs_addr;
            ex_rt_d     = rt_addr;
            ex_dst_d    = dst_sel;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (id_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= CTRL_W'(NOP_CTRL);
            ex_pc4_q    <= '0;
            ex_rs_val_q <= '0;
            ex_rt_val_q <= '0;
            ex_imm_q    <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_dst_q    <= '0;
            cnt_q       <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_pc4_q    <= ex_pc4_d;
            ex_rs_val_q <= ex_rs_val_d;
            ex_rt_val_q <= ex_rt_val_d;
            ex_imm_q    <= ex_imm_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_dst_q    <= ex_dst_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.rs_addr      = rs_addr;
    assign bus.rt_addr      = rt_addr;
    assign bus.id_stall     = id_stall;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_pc4       = ex_pc4_q;
    assign bus.ex_rs_val    = ex_rs_val_q;
    assign bus.ex_rt_val    = ex_rt_val_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_dst       = ex_dst_q;
    assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a reference model pushes the expected ID/EX
// contents each cycle and the scoreboard pops them after the clock edge.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 10;   // narrow counter keeps the saturation run short
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [CTRL_W-1:0] C_LW  = CTRL_W'((1 << CTRL_REGWR) | (1 << CTRL_MEMRD) |
                                                  (1 << CTRL_MEMTOREG) | (1 << CTRL_ALUSRC));
    localparam logic [CTRL_W-1:0] C_R   = CTRL_W'((1 << CTRL_REGWR) | (1 << CTRL_REGDST));
    localparam logic [CTRL_W-1:0] C_IMM = CTRL_W'((1 << CTRL_REGWR) | (1 << CTRL_ALUSRC));
    localparam logic [CTRL_W-1:0] C_SW  = CTRL_W'((1 << CTRL_MEMWR) | (1 << CTRL_ALUSRC));

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [31:0]       pc4;
        logic [31:0]       rs_val;
        logic [31:0]       rt_val;
        logic [31:0]       imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dst;
    } ex_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    ex_t  exp_q[$];
    ex_t  mdl_ex = '0;
    int   mdl_cnt = 0;
    int   stall_total = 0;
    logic [31:0] pc4 = 32'h0040_0000;

    id_ex_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".id_stall"},  32'(bus.id_stall),     32'd0);
        check({tag, ".ex_valid"},  32'(bus.ex_valid),     32'd0);
        check({tag, ".ex_ctrl"},   32'(bus.ex_ctrl),      32'd0);
        check({tag, ".ex_pc4"},    bus.ex_pc4,            32'd0);
        check({tag, ".ex_rs_val"}, bus.ex_rs_val,         32'd0);
        check({tag, ".ex_rt_val"}, bus.ex_rt_val,         32'd0);
        check({tag, ".ex_imm"},    bus.ex_imm,            32'd0);
        check({tag, ".ex_rs"},     32'(bus.ex_rs),        32'd0);
        check({tag, ".ex_rt"},     32'(bus.ex_rt),        32'd0);
        check({tag, ".ex_dst"},    32'(bus.ex_dst),       32'd0);
        check({tag, ".stall_cyc"}, 32'(bus.stall_cycles), 32'd0);
    endtask

    task automatic set_id(input logic [31:0] instr, input logic [CTRL_W-1:0] ctrl,
                          input logic urs, input logic urt,
                          input logic [31:0] r1, input logic [31:0] r2);
        bus.id_valid   = 1'b1;
        bus.id_instr   = instr;
        bus.id_ctrl    = ctrl;
        bus.id_uses_rs = urs;
        bus.id_uses_rt = urt;
        bus.rd1        = r1;
        bus.rd2        = r2;
        pc4            = pc4 + 32'd4;
        bus.id_pc4     = pc4;
    endtask

    task automatic set_wb(input logic wr, input logic [4:0] addr, input logic [31:0] data);
        bus.wb_regwr  = wr;
        bus.wb_wraddr = addr;
        bus.wb_data   = data;
    endtask

    // One clock: check combinational outputs, push the model's ID/EX entry, pop and compare after the edge
    task automatic cycle(input string tag);
        ex_t         nxt;
        ex_t         got;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        haz;
        logic        stall;
        @(negedge clk);
        rs  = bus.id_instr[25:21];
        rt  = bus.id_instr[20:16];
        op1 = (bus.wb_regwr && bus.wb_wraddr != 5'd0 && bus.wb_wraddr == rs) ? bus.wb_data : bus.rd1;
        op2 = (bus.wb_regwr && bus.wb_wraddr != 5'd0 && bus.wb_wraddr == rt) ? bus.wb_data : bus.rd2;
        haz = bus.id_valid && mdl_ex.valid && mdl_ex.ctrl[CTRL_MEMRD] && mdl_ex.dst != 5'd0 &&
              ((bus.id_uses_rs && mdl_ex.dst == rs) || (bus.id_uses_rt && mdl_ex.dst == rt));
        stall = haz && !bus.ex_flush;
        check({tag, ".rs_addr"},  32'(bus.rs_addr),  32'(rs));
        check({tag, ".rt_addr"},  32'(bus.rt_addr),  32'(rt));
        check({tag, ".id_stall"}, 32'(bus.id_stall), 32'(stall));
        nxt = '0;
        if (!bus.ex_flush && !stall) begin
            nxt.valid  = bus.id_valid;
            nxt.ctrl   = bus.id_valid ? bus.id_ctrl : '0;
            nxt.pc4    = bus.id_pc4;
            nxt.rs_val = op1;
            nxt.rt_val = op2;
            nxt.imm    = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
            nxt.rs     = rs;
            nxt.rt     = rt;
            nxt.dst    = bus.id_ctrl[CTRL_REGDST] ? bus.id_instr[15:11] : bus.id_instr[20:16];
        end
        if (stall) begin
            stall_total++;
            if (mdl_cnt != CNT_MAX) mdl_cnt++;
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end else begin
            got = exp_q.pop_front();
            check({tag, ".ex_valid"},  32'(bus.ex_valid), 32'(got.valid));
            check({tag, ".ex_ctrl"},   32'(bus.ex_ctrl),  32'(got.ctrl));
            check({tag, ".ex_pc4"},    bus.ex_pc4,        got.pc4);
            check({tag, ".ex_rs_val"}, bus.ex_rs_val,     got.rs_val);
            check({tag, ".ex_rt_val"}, bus.ex_rt_val,     got.rt_val);
            check({tag, ".ex_imm"},    bus.ex_imm,        got.imm);
            check({tag, ".ex_rs"},     32'(bus.ex_rs),    32'(got.rs));
            check({tag, ".ex_rt"},     32'(bus.ex_rt),    32'(got.rt));
            check({tag, ".ex_dst"},    32'(bus.ex_dst),   32'(got.dst));
            mdl_ex = got;
        end
        check({tag, ".stall_cyc"}, 32'(bus.stall_cycles), 32'(mdl_cnt));
    endtask

    initial begin
        int target;
        rst_n = 1'b0;
        bus.id_valid = 1'b0;
        bus.id_instr = '0;
        bus.id_pc4 = '0;
        bus.id_ctrl = '0;
        bus.id_uses_rs = 1'b0;
        bus.id_uses_rt = 1'b0;
        bus.rd1 = '0;
        bus.rd2 = '0;
        bus.ex_flush = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // lw $8,0($0) then add $9,$8,$8: one stall, bubble, then add in EX
        set_id(32'h8C08_0000, C_LW, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle("lw");
        set_id(32'h0108_4820, C_R, 1'b1, 1'b1, 32'h11, 32'h11);
        cycle("add.stall");
        check("add.stall.bubble", 32'(bus.ex_valid), 32'd0);
        cycle("add.adv");
        check("add.adv.dst", 32'(bus.ex_dst), 32'd9);
        check("add.adv.cnt", 32'(bus.stall_cycles), 32'd1);

        // addi $6,$5,1 with WB writing $5 in the same cycle
        set_id(32'h20A6_0001, C_IMM, 1'b1, 1'b0, 32'h1, 32'h0);
        set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        cycle("bypass");
        check("bypass.rs_val", bus.ex_rs_val, 32'hDEAD_BEEF);

        // addi $6,$0,1 with WB writing $0: no forwarding
        set_id(32'h2006_0001, C_IMM, 1'b1, 1'b0, 32'h0, 32'h0);
        set_wb(1'b1, 5'd0, 32'h0000_1234);
        cycle("wb0");
        check("wb0.rs_val", bus.ex_rs_val, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);

        // load-use pair with flush in the same cycle
        set_id(32'h8C08_0000, C_LW, 1'b1, 1'b0, 32'd0, 32'd0);
        cycle("flush.lw");
        set_id(32'h0108_4820, C_R, 1'b1, 1'b1, 32'h11, 32'h11);
        bus.ex_flush = 1'b1;
        cycle("flush.add");
        check("flush.bubble", 32'(bus.ex_valid), 32'd0);
        check("flush.cnt", 32'(bus.stall_cycles), 32'd1);
        bus.ex_flush = 1'b0;

        // immediate sign extension, R-type destination, store, invalid slot
        set_id(32'h2067_8000, C_IMM, 1'b1, 1'b0, 32'h33, 32'h0);
        cycle("addi.neg");
        check("addi.neg.imm", bus.ex_imm, 32'hFFFF_8000);
        check("addi.neg.dst", 32'(bus.ex_dst), 32'd7);
        set_id(32'h0022_8820, C_R, 1'b1, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002);
        cycle("rtype");
        check("rtype.dst", 32'(bus.ex_dst), 32'd17);
        set_id(32'hAC44_0008, C_SW, 1'b1, 1'b1, 32'h1000, 32'hCAFE);
        cycle("sw");
        set_id(32'h0022_8820, C_R, 1'b1, 1'b1, 32'h1, 32'h2);
        bus.id_valid = 1'b0;
        cycle("invalid");
        check("invalid.ctrl", 32'(bus.ex_ctrl), 32'd0);

        // chain of lw $8,0($8): every other cycle stalls until the counter saturates
        target = stall_total + (1 << CNT_W) + 3;
        set_id(32'h8D08_0000, C_LW, 1'b1, 1'b0, 32'h100, 32'h0);
        for (int i = 0; i < 3 * ((1 << CNT_W) + 3) + 10 && stall_total < target; i++) begin
            cycle("sat");
        end
        if (stall_total < target) begin
            checks++;
            errors++;
            $error("FAIL sat.bound: observed %0d stalls expected %0d", stall_total, target);
        end
        check("sat.cnt", 32'(bus.stall_cycles), 32'(CNT_MAX));

        // get a load into EX, then drop reset while the stall is active
        cycle("sat.load");
        #2;
        check("rst.pre.stall", 32'(bus.id_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst.mid");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mdl_ex  = '0;
        mdl_cnt = 0;
        exp_q.delete();
        set_id(32'h0108_4820, C_R, 1'b1, 1'b1, 32'h7, 32'h8);
        cycle("post.rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute boundary of the 5-stage MIPS pipeline, sitting directly downstream of the register file. It drives the register-file read addresses from the IF/ID instruction and bypasses the same-cycle writeback value onto the read data. It detects load-use hazards and stalls IF/ID with a bubble, and registers operands plus control into the ID/EX pipeline register. It also counts stall cycles for performance debug.

## Interface
Parameters:
- CTRL_W, 8, width of control bundle from the main control unit; bit indices fixed in package
- CNT_W, 16, width of saturating stall counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- id_valid  in  1  IF/ID holds a valid instruction
- id_instr  in  32  instruction in ID
- id_pc4  in  32  PC+4 of that instruction
- id_ctrl  in  CTRL_W  decoded control (REGWR, MEMRD, MEMWR, MEMTOREG, ALUSRC, REGDST, …)
- id_uses_rs / id_uses_rt  in  1 each  instruction reads rs / rt
- rs_addr / rt_addr  out  5 each  to regfile RdReg1/RdReg2: id_instr[25:21] / [20:16]
- rd1 / rd2  in  32 each  regfile read data
- wb_regwr  in  1; wb_wraddr  in  5; wb_data  in  32  same signals driving the regfile write port
- ex_flush  in  1  taken branch/jump resolved in EX; kill ID
- id_stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1; ex_ctrl  out  CTRL_W; ex_pc4  out  32
- ex_rs_val / ex_rt_val  out  32 each; ex_imm  out  32  sign-extended id_instr[15:0]
- ex_rs / ex_rt / ex_dst  out  5 each  source and destination register numbers
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Bypass: op1 = wb_data when wb_regwr && wb_wraddr!=0 && wb_wraddr==rs_addr, else rd1; op2 likewise on rt_addr/rd2. Needed because the regfile array updates only at the posedge.
- Destination: ex_dst source = id_ctrl[REGDST] ? id_instr[15:11] : id_instr[20:16].
- Load-use hazard (combinational) = id_valid && ex_valid && ex_ctrl[MEMRD] && ex_dst!=0 && ((id_uses_rs && ex_dst==rs_addr) || (id_uses_rt && ex_dst==rt_addr)).
- id_stall = hazard && !ex_flush.
- The ID/EX register has three mutually exclusive update modes, in priority order:
  - FLUSH (ex_flush=1): load bubble.
  - STALL (id_stall=1): load bubble; the ID instruction stays in IF/ID.
  - ADVANCE: load the ID instruction; ex_valid=id_valid, and ex_ctrl=id_valid ? id_ctrl : 0.
- Bubble: ex_valid=0, ex_ctrl=0 (NOP_CTRL); the other ex_* fields hold don't-care values and are loaded with 0.
- stall_cycles increments on each cycle with id_stall=1 and saturates at all-ones.

## Timing
- Reset: every ex_* output is 0, stall_cycles=0, and id_stall=0 (ex_valid=0 forces hazard 0).
- rs_addr/rt_addr, the bypass mux and id_stall are combinational within the ID cycle.
- ex_* outputs are valid one cycle after ID; latency is 1.
- A load-use pair gives exactly one stall cycle. The bubble then sits in EX, so the stall releases the next cycle.
- Simultaneous flush and hazard: flush wins, id_stall=0, and the counter does not increment.
- Simultaneous WB write to $0: no bypass and no hazard; reads of $0 are always 0 via the regfile.
- Reset asserted mid-stall clears the pipeline register and the counter immediately, without waiting for a clock edge.

## Structure
- Shared package mips_pipe_pkg holds:
  - control bit indices (CTRL_REGWR=0, CTRL_MEMRD=1, CTRL_MEMWR=2, CTRL_MEMTOREG=3, CTRL_ALUSRC=4, CTRL_REGDST=5)
  - the NOP_CTRL constant
  - the field slice constants for rs, rt, rd and imm
- One combinational sub-module, id_hazard_unit, contains the load-use compare and produces id_stall.
- Bypass muxes, the pipeline register and the counter stay in the top module.

## Test plan
- Reset then `lw $8,0($0)` followed by `add $9,$8,$8`: id_stall=1 for one cycle, ex_valid=0 on the following cycle, then the add reaches EX; stall_cycles=1.
- WB writes $5=0xDEADBEEF in the same cycle ID reads rs=$5 while regfile rd1 still shows the old value 0x1 → ex_rs_val=0xDEADBEEF.
- WB write to $0 with value 0x1234 while ID reads rs=$0 → ex_rs_val=0.
- Load-use hazard with ex_flush=1 in the same cycle → id_stall=0, bubble in EX, stall_cycles unchanged.
- addi with imm 0x8000 → ex_imm=0xFFFF8000 and ex_dst=rt; an R-type instruction with rd=17 → ex_dst=17.
- Force 2^CNT_W+3 stall cycles → stall_cycles stays at 0xFFFF; rst_n low mid-stall → all outputs 0 immediately.
